ioctl_rom_router: RTL

- Parametrised ROM download router between the hps_io ioctl byte stream and up to NUM_REGIONS on-board memory ports (SDRAM controller, BRAM ROMs).
- Decodes the download address into regions, packs bytes into DATA_W words and issues one-word write requests with a req/ack handshake.
- Back-pressures HPS through ioctl_wait and captures DIP bytes from a dedicated ioctl index.
- Successor to the per-game hardwired loaders in the emu top level; it generalises width, region count and flush behaviour.

---
 rtl/rom_router_pkg.sv | 26 ++
 rtl/rom_router_pack.sv | 81 ++++++++
 rtl/ioctl_rom_router.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rom_router_pkg.sv
// Shared types and helpers for the ioctl ROM download router.
package rom_router_pkg;

  typedef enum logic [2:0] {IDLE, COLLECT, REQ, FLUSH_END, DONE} state_t;

  localparam logic [7:0]  PAD_BYTE  = 8'hFF;
  localparam logic [31:0] DIP_RESET = 32'hFFFF_FFFF;
  localparam int          MAX_RGN   = 8;

  typedef logic [MAX_RGN*27-1:0] bases_t;

  // Bases are packed first-region-at-MSB, so region k sits (n-1-k) slots up.
  function automatic logic [26:0] rgn_base_of(input bases_t bases, input int n, input int k);
    return bases[(n-1-k)*27 +: 27];
  endfunction

  function automatic logic [MAX_RGN-1:0] rgn_decode(input logic [26:0] addr, input bases_t bases,
                                                    input int n);
    logic [MAX_RGN-1:0] oh;
    oh = '0;
    for (int k = 0; k < MAX_RGN; k++)
      if (k < n && addr >= rgn_base_of(bases, n, k)) oh = MAX_RGN'(1) << k;
    return oh;
  endfunction

endpackage

// File: rtl/rom_router_pack.sv
// Byte-lane packer: assembles one DATA_W word with byte enables plus a one-byte skid slot.
module rom_router_pack
  import rom_router_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 24,
  parameter int LW          = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init,
  input  logic                   store,
  input  logic                   push,
  input  logic                   ack,
  input  logic [NUM_REGIONS-1:0] in_rgn,
  input  logic [ADDR_W-1:0]      in_waddr,
  input  logic [LW-1:0]          in_lane,
  input  logic [7:0]             in_data,
  output logic [NUM_REGIONS-1:0] buf_rgn,
  output logic [ADDR_W-1:0]      buf_waddr,
  output logic [DATA_W-1:0]      buf_data,
  output logic [DATA_W/8-1:0]    buf_be,
  output logic                   buf_empty,
  output logic                   conflict,
  output logic                   skid_vld,
  output logic                   skid_top
);
  localparam int LANES = DATA_W/8;

  logic [LANES-1:0][7:0]  data_q;
  logic [LANES-1:0]       be_q;
  logic [NUM_REGIONS-1:0] rgn_q, sk_rgn;
  logic [ADDR_W-1:0]      waddr_q, sk_waddr;
  logic [LW-1:0]          sk_lane;
  logic [7:0]             sk_data;
  logic                   sk_vld;
  logic                   push_direct;

  // A byte racing the ack with an empty skid goes straight into the fresh word.
  assign push_direct = ack && push && !sk_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {LANES{PAD_BYTE}}; be_q <= '0; rgn_q <= '0; waddr_q <= '0;
      sk_rgn <= '0; sk_waddr <= '0; sk_lane <= '0; sk_data <= '0; sk_vld <= 1'b0;
    end else if (init) begin
      data_q <= {LANES{PAD_BYTE}}; be_q <= '0; sk_vld <= 1'b0;
    end else begin
      if (ack) begin
        data_q <= {LANES{PAD_BYTE}};
        be_q   <= '0;
        sk_vld <= 1'b0;
        if (sk_vld) begin
          data_q[sk_lane] <= sk_data; be_q[sk_lane] <= 1'b1;
          rgn_q <= sk_rgn; waddr_q <= sk_waddr;
        end else if (push_direct) begin
          data_q[in_lane] <= in_data; be_q[in_lane] <= 1'b1;
          rgn_q <= in_rgn; waddr_q <= in_waddr;
        end
      end else if (store) begin
        data_q[in_lane] <= in_data; be_q[in_lane] <= 1'b1;
        rgn_q <= in_rgn; waddr_q <= in_waddr;
      end
      if (push && !push_direct) begin
        sk_rgn <= in_rgn; sk_waddr <= in_waddr; sk_lane <= in_lane; sk_data <= in_data;
        sk_vld <= 1'b1;
      end
    end
  end

  assign buf_rgn   = rgn_q;
  assign buf_waddr = waddr_q;
  assign buf_data  = data_q;
  assign buf_be    = be_q;
  assign buf_empty = (be_q == '0);
  assign conflict  = !buf_empty && (in_rgn != rgn_q || in_waddr != waddr_q);
  assign skid_vld  = sk_vld;
  assign skid_top  = (sk_lane == LW'(LANES-1));

endmodule

// File: rtl/ioctl_rom_router.sv
// hps_io ioctl download router: region decode, word packing, req/ack writes, DIP capture.
// Optional o_CSUM byte checksum output when ROM_ROUTER_CHECKSUM_EN is defined.
module ioctl_rom_router
  import rom_router_pkg::*;
#(
  parameter int                        NUM_REGIONS = 4,
  parameter int                        DATA_W      = 16,
  parameter int                        ADDR_W      = 24,
  parameter logic [NUM_REGIONS*27-1:0] REGION_BASE = {27'h0, 27'h20000, 27'h40000, 27'h60000},
  parameter logic [15:0]               ROM_INDEX   = 16'd0,
  parameter logic [15:0]               DIP_INDEX   = 16'd254
) (
  input  logic                   i_EMU_MCLK,
  input  logic                   i_EMU_INITRST_n,
  input  logic [15:0]            ioctl_index,
  input  logic                   ioctl_download,
  input  logic [26:0]            ioctl_addr,
  input  logic [7:0]             ioctl_data,
  input  logic                   ioctl_wr,
  output logic                   ioctl_wait,
  output logic                   o_MEM_REQ,
  output logic [NUM_REGIONS-1:0] o_MEM_RGN,
  output logic [ADDR_W-1:0]      o_MEM_ADDR,
  output logic [DATA_W-1:0]      o_MEM_DATA,
  output logic [DATA_W/8-1:0]    o_MEM_BE,
  input  logic                   i_MEM_ACK,
  output logic [31:0]            o_DIPSW,
`ifdef ROM_ROUTER_CHECKSUM_EN
  output logic [15:0]            o_CSUM,
`endif
  output logic                   o_BUSY,
  output logic                   o_DONE
);
  localparam int             LANES = DATA_W/8;
  localparam int             LB    = $clog2(LANES);
  localparam int             LW    = (LB > 0) ? LB : 1;
  localparam logic [LW-1:0]  TOP   = LW'(LANES-1);
  localparam bases_t         BASES = bases_t'(REGION_BASE);

  state_t                 state_q, state_d;
  logic                   dl_q;
  logic [NUM_REGIONS-1:0] in_rgn, buf_rgn;
  logic [26:0]            base_sel, rel;
  logic [ADDR_W-1:0]      in_waddr, buf_waddr;
  logic [LW-1:0]          in_lane;
  logic [DATA_W-1:0]      buf_data;
  logic [LANES-1:0]       buf_be;
  logic                   buf_empty, conflict, skid_vld, skid_top;
  logic                   rom_sel, rom_wr, init, store, push, ack, req;
  logic [3:0][7:0]        dip_q;

  assign in_rgn = NUM_REGIONS'(rgn_decode(ioctl_addr, BASES, NUM_REGIONS));

  always_comb begin
    base_sel = '0;
    for (int k = 0; k < NUM_REGIONS; k++)
      if (in_rgn[k]) base_sel = rgn_base_of(BASES, NUM_REGIONS, k);
  end

  assign rel      = ioctl_addr - base_sel;
  assign in_lane  = LW'(rel) & LW'(LANES-1);
  assign in_waddr = ADDR_W'(rel >> LB);
  assign rom_sel  = (ioctl_index == ROM_INDEX);
  // Bytes below the first region decode to no region and are dropped here.
  assign rom_wr   = ioctl_wr && rom_sel && (|in_rgn);

  always_comb begin
    state_d = state_q;
    init = 1'b0; store = 1'b0; push = 1'b0; ack = 1'b0;
    case (state_q)
      IDLE: if (ioctl_download && !dl_q && rom_sel) begin
        state_d = COLLECT;
        init    = 1'b1;
      end
      COLLECT: begin
        if (rom_wr) begin
          if (conflict) begin
            push    = 1'b1;
            state_d = REQ;
          end else begin
            store = 1'b1;
            if (in_lane == TOP) state_d = REQ;
          end
        end else if (!ioctl_download) begin
          state_d = buf_empty ? DONE : FLUSH_END;
        end
      end
      REQ: begin
        if (rom_wr && !skid_vld) push = 1'b1;
        if (i_MEM_ACK) begin
          ack = 1'b1;
          // The byte reloaded on ack may itself complete a word.
          if (skid_vld ? skid_top : (push && in_lane == TOP)) state_d = REQ;
          else state_d = COLLECT;
        end
      end
      FLUSH_END: if (i_MEM_ACK) begin
        ack     = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
    end
  end

  rom_router_pack #(
    .NUM_REGIONS(NUM_REGIONS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LW(LW)
  ) u_pack (
    .clk(i_EMU_MCLK), .rst_n(i_EMU_INITRST_n), .init(init), .store(store), .push(push),
    .ack(ack), .in_rgn(in_rgn), .in_waddr(in_waddr), .in_lane(in_lane), .in_data(ioctl_data),
    .buf_rgn(buf_rgn), .buf_waddr(buf_waddr), .buf_data(buf_data), .buf_be(buf_be),
    .buf_empty(buf_empty), .conflict(conflict), .skid_vld(skid_vld), .skid_top(skid_top)
  );

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) dip_q <= DIP_RESET;
    else if (ioctl_download && ioctl_index == DIP_INDEX && ioctl_wr && ioctl_addr < 27'd4)
      dip_q[ioctl_addr[1:0]] <= ioctl_data;
  end

`ifdef ROM_ROUTER_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) csum_q <= '0;
    else if (init) csum_q <= '0;
    else if (store || push) csum_q <= csum_q + 16'(ioctl_data);
  end
  assign o_CSUM = csum_q;
`endif

  assign req        = (state_q == REQ) || (state_q == FLUSH_END);
  assign o_MEM_REQ  = req;
  assign ioctl_wait = req;
  assign o_MEM_RGN  = req ? buf_rgn   : '0;
  assign o_MEM_ADDR = req ? buf_waddr : '0;
  assign o_MEM_DATA = req ? buf_data  : '0;
  assign o_MEM_BE   = req ? buf_be    : '0;
  assign o_DIPSW    = dip_q;
  assign o_BUSY     = (state_q != IDLE);
  assign o_DONE     = (state_q == DONE);

endmodule
